// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for a radix-2 Booth multiplier datapath (one multiply in flight).
// Optional count cross-check enabled by defining BOOTH_SEQ_CHECK_EN.
module booth_seq_ctrl #(
  parameter int unsigned WIDTH_IN = 16,
  parameter int unsigned WIDTH_IT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       src_valid,
  output logic       src_ready,
  output logic       dst_valid,
  input  logic       dst_ready,
  input  logic       clr,
  input  logic [1:0] booth_bits,
  input  logic       count_16,
  output logic       en_i,
  output logic       valid_in,
  output logic       en_pp,
  output logic       en_fp,
  output logic [1:0] sel,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCalc  = 2'd1,
    StFinal = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [WIDTH_IT-1:0] LastIter = WIDTH_IT'(WIDTH_IN - 1);

  state_e              state_q, state_d;
  logic [WIDTH_IT-1:0] iter_q, iter_d;
  logic                accept;

  assign accept = (state_q == StIdle) && src_valid && !clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    if (clr) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (src_valid) begin
            state_d = StCalc;
            iter_d  = '0;
          end
        end
        StCalc: begin
          iter_d = iter_q + 1'b1;
          if (iter_q == LastIter) state_d = StFinal;
        end
        StFinal: state_d = StDone;
        StDone:  if (dst_ready) state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    src_ready = 1'b0;
    en_i      = 1'b0;
    valid_in  = 1'b0;
    en_pp     = 1'b0;
    en_fp     = 1'b0;
    sel       = 2'b00;
    dst_valid = 1'b0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        src_ready = !clr;
        en_i      = accept;
        valid_in  = accept;
      end
      StCalc: begin
        en_pp = !clr;
        // {Q0,Q-1}: 01 adds A, 10 subtracts A, equal bits only shift.
        if (!clr) begin
          case (booth_bits)
            2'b01:   sel = 2'b01;
            2'b10:   sel = 2'b10;
            default: sel = 2'b00;
          endcase
        end
      end
      StFinal: en_fp = !clr;
      StDone:  dst_valid = 1'b1;
    endcase
  end

`ifdef BOOTH_SEQ_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if ((state_q == StCalc && count_16) || (state_q == StFinal && !count_16)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_count_16;
  assign unused_count_16 = count_16;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Randomized self-checking bench for booth_seq_ctrl with a behavioural Booth datapath model.
module tb_booth_seq_ctrl;

  logic       clk, reset, src_valid, src_ready, dst_valid, dst_ready, clr;
  logic [1:0] booth_bits, sel;
  logic       count_16, en_i, valid_in, en_pp, en_fp, busy, err;

  booth_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .dst_valid  (dst_valid),
    .dst_ready  (dst_ready),
    .clr        (clr),
    .booth_bits (booth_bits),
    .count_16   (count_16),
    .en_i       (en_i),
    .valid_in   (valid_in),
    .en_pp      (en_pp),
    .en_fp      (en_fp),
    .sel        (sel),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Datapath model: operand buses, P = {hi[16:0], lo[15:0], Q-1}, iteration counter.
  logic [15:0] a_in, b_in, a_q;
  logic [33:0] p_q;
  logic [4:0]  cnt_q;
  logic [31:0] prod_q;
  logic        force_c16;
  logic        en_i_s, en_pp_s, en_fp_s;
  logic [1:0]  sel_s;

  assign booth_bits = p_q[1:0];
  assign count_16   = force_c16 ? 1'b0 : (cnt_q == 5'd16);

  function automatic logic [33:0] booth_step(input logic [33:0] p, input logic [15:0] a,
                                             input logic [1:0] s);
    logic [16:0] hi;
    hi = p[33:17];
    if (s == 2'b01)      hi = hi + {a[15], a};
    else if (s == 2'b10) hi = hi - {a[15], a};
    return {hi[16], hi, p[16:1]};
  endfunction

  always @(negedge clk) begin
    en_i_s  <= en_i;
    en_pp_s <= en_pp;
    en_fp_s <= en_fp;
    sel_s   <= sel;
  end

  always @(posedge clk) begin
    if (reset) begin
      p_q    <= '0;
      a_q    <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      if (en_i_s) begin
        p_q   <= {17'd0, b_in, 1'b0};
        a_q   <= a_in;
        cnt_q <= '0;
      end else if (en_pp_s) begin
        p_q   <= booth_step(p_q, a_q, sel_s);
        cnt_q <= cnt_q + 5'd1;
      end
      if (en_fp_s) prod_q <= p_q[32:1];
    end
  end

`ifdef BOOTH_SEQ_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  bit bad_final;
  bit err_exp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_sel(input logic [1:0] pair);
    if (pair == 2'b01) return 2'b01;
    if (pair == 2'b10) return 2'b10;
    return 2'b00;
  endfunction

  // Full transaction from the accept cycle to the output handshake.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int unsigned rdly,
                         input bit hold_src);
    logic [31:0] exp_p;
    logic [16:0] bx;
    exp_p = 32'($signed(a) * $signed(b));
    bx    = {b, 1'b0};
    a_in = a;
    b_in = b;
    src_valid = 1'b1;
    dst_ready = 1'b0;
    @(negedge clk);
    check_val("acc_src_ready", 32'(src_ready), 32'd1);
    check_val("acc_en_i", 32'(en_i), 32'd1);
    check_val("acc_valid_in", 32'(valid_in), 32'd1);
    check_val("acc_err", 32'(err), 32'(err_exp));
    step();
    err_exp = 1'b0;
    src_valid = hold_src;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check_val($sformatf("calc%0d_en_pp", k), 32'(en_pp), 32'd1);
      check_val($sformatf("calc%0d_sel", k), 32'(sel), 32'(exp_sel({bx[k+1], bx[k]})));
      check_val($sformatf("calc%0d_en_i", k), 32'(en_i), 32'd0);
      if (k == 0) check_val("calc_err", 32'(err), 32'd0);
      step();
    end
    force_c16 = bad_final;
    @(negedge clk);
    check_val("final_en_fp", 32'(en_fp), 32'd1);
    check_val("final_en_pp", 32'(en_pp), 32'd0);
    check_val("final_sel", 32'(sel), 32'd0);
    check_val("final_dst_valid", 32'(dst_valid), 32'd0);
    step();
    force_c16 = 1'b0;
    if (bad_final && CheckEn) err_exp = 1'b1;
    for (int d = 0; d < int'(rdly); d++) begin
      @(negedge clk);
      check_val("wait_dst_valid", 32'(dst_valid), 32'd1);
      check_val("wait_src_ready", 32'(src_ready), 32'd0);
      check_val("wait_en_i", 32'(en_i), 32'd0);
      check_val("wait_err", 32'(err), 32'(err_exp));
      step();
    end
    dst_ready = 1'b1;
    @(negedge clk);
    check_val("done_dst_valid", 32'(dst_valid), 32'd1);
    check_val("done_src_ready", 32'(src_ready), 32'd0);
    check_val("done_product", prod_q, exp_p);
    step();
    dst_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_fp, seen_dv;
    reset = 1'b1; clr = 1'b0; src_valid = 1'b0; dst_ready = 1'b0;
    a_in = '0; b_in = '0; force_c16 = 1'b0; bad_final = 1'b0; err_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_src_ready", 32'(src_ready), 32'd1);
    check_val("rst_en_i", 32'(en_i), 32'd0);
    check_val("rst_valid_in", 32'(valid_in), 32'd0);
    check_val("rst_en_pp", 32'(en_pp), 32'd0);
    check_val("rst_en_fp", 32'(en_fp), 32'd0);
    check_val("rst_dst_valid", 32'(dst_valid), 32'd0);
    check_val("rst_sel", 32'(sel), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    step();

    run_mul(16'd3, 16'd5, 0, 1'b0);
    check_val("prod_3x5", prod_q, 32'h0000_000F);
    run_mul(16'hFFF9, 16'd9, 0, 1'b0);
    check_val("prod_m7x9", prod_q, 32'hFFFF_FFC1);
    run_mul(16'h8000, 16'h8000, 0, 1'b0);
    check_val("prod_min_sq", prod_q, 32'h4000_0000);

    // Stall five cycles, then back-to-back accept with src_valid held.
    run_mul(16'h1234, 16'h5678, 5, 1'b1);
    run_mul(16'h0007, 16'hFFFF, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_mul(16'($urandom), 16'($urandom), $urandom_range(0, 3), 1'b0);
    end

    // clr with src_valid in IDLE blocks the accept.
    src_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    check_val("clr_idle_src_ready", 32'(src_ready), 32'd0);
    check_val("clr_idle_en_i", 32'(en_i), 32'd0);
    step();
    clr = 1'b0; src_valid = 1'b0;
    @(negedge clk);
    check_val("clr_idle_busy", 32'(busy), 32'd0);
    step();

    // clr at CALC iteration 8.
    a_in = 16'h1234; b_in = 16'h0055; src_valid = 1'b1;
    step();
    src_valid = 1'b0;
    repeat (8) step();
    clr = 1'b1;
    @(negedge clk);
    check_val("clr_calc_en_pp", 32'(en_pp), 32'd0);
    step();
    clr = 1'b0;
    @(negedge clk);
    check_val("clr_after_busy", 32'(busy), 32'd0);
    check_val("clr_after_src_ready", 32'(src_ready), 32'd1);
    seen_fp = 1'b0; seen_dv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge clk);
      seen_fp |= en_fp;
      seen_dv |= dst_valid;
    end
    check_val("clr_no_en_fp", 32'(seen_fp), 32'd0);
    check_val("clr_no_dst_valid", 32'(seen_dv), 32'd0);
    step();
    run_mul(16'd2, 16'd2, 0, 1'b0);
    check_val("prod_2x2", prod_q, 32'd4);

    // Asynchronous reset during FINAL.
    a_in = 16'h00AB; b_in = 16'h0C0D; src_valid = 1'b1;
    step();
    src_valid = 1'b0;
    repeat (16) step();
    @(negedge clk);
    check_val("pre_rst_en_fp", 32'(en_fp), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_val("arst_en_fp", 32'(en_fp), 32'd0);
    check_val("arst_en_pp", 32'(en_pp), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_dst_valid", 32'(dst_valid), 32'd0);
    step();
    step();
    reset = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    check_val("arst_rel_src_ready", 32'(src_ready), 32'd1);
    check_val("arst_rel_dst_valid", 32'(dst_valid), 32'd0);
    check_val("arst_rel_busy", 32'(busy), 32'd0);
    step();

    // count_16 low in FINAL: err only with the cross-check built in.
    bad_final = 1'b1;
    run_mul(16'h0011, 16'h0022, 2, 1'b0);
    bad_final = 1'b0;
    @(negedge clk);
    check_val("err_idle_hold", 32'(err), 32'(CheckEn));
    step();
    run_mul(16'd5, 16'd6, 0, 1'b0);
    check_val("prod_5x6", prod_q, 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
